chip8_alu_sequencer: RTL and testbench
======================================

# chip8_alu_sequencer

Multi-cycle controller that executes Chip-8 8XYn register arithmetic instructions by sequencing the shared combinational `Chip8_ALU` and the V-register file. It reads Vx and Vy and drives the ALU select and operands. It then writes the 8-bit result to Vx and the flag to VF as two separate write cycles over a single write port. It sits between the instruction decoder (start/done handshake) and the register file/ALU pair.

## Interface
Parameters: none (data width fixed at 8-bit V-registers, 16-bit ALU operands).

- `clk` in 1: system clock, all state updates on rising edge
- `reset_n` in 1: synchronous, active-low reset
- `start` in 1: request to execute; sampled only in IDLE
- `op_x` in 4: X register index
- `op_y` in 4: Y register index
- `op_n` in 4: low nibble of 8XYn
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle
- `done` out 1: one-cycle completion pulse
- `err` out 1: one-cycle pulse coincident with `done` for an unsupported `op_n`
- `rf_raddr_a` out 4: read address A (Vx)
- `rf_raddr_b` out 4: read address B (Vy)
- `rf_rdata_a` in 8: synchronous read data A, valid the cycle after the address
- `rf_rdata_b` in 8: synchronous read data B, valid the cycle after the address
- `rf_we` out 1: register write enable
- `rf_waddr` out 4: write address
- `rf_wdata` out 8: write data
- `alu_sel` out ALU_f: ALU function select; ALU_f_NOP when not in EXEC
- `alu_in1` out 16: ALU operand 1
- `alu_in2` out 16: ALU operand 2
- `alu_out` in 16: ALU result
- `alu_carry` in 16: ALU carry output; ignored by this block

## Operation
- States: IDLE, READ, EXEC, WR_VX, WR_VF, DONE.
- IDLE:
  - `start`=1 with valid n latches x, y, n and goes to READ.
  - `start`=1 with invalid n (not 0-7 or E) goes straight to DONE with `err`=1. No register reads or writes occur.
  - `start` while busy is ignored.
- READ: drive `rf_raddr_a`=x and `rf_raddr_b`=y, then go to EXEC.
- EXEC: both read-data buses are zero-extended to 16 bits. The ALU select and operands are decoded from n; `alu_out` is registered as the result and the flag is registered with it. Go to WR_VX.
  - n=0: OR, Vy | 0; no flag.
  - n=1: OR, Vx, Vy; no flag.
  - n=2: AND, Vx, Vy; no flag.
  - n=3: XOR, Vx, Vy; no flag.
  - n=4: ADD, Vx, Vy; flag = `alu_out[8]`.
  - n=5: MINUS, Vx, Vy; flag = ~`alu_out[15]`, i.e. 1 when Vx ≥ Vy.
  - n=6: RSHIFT, Vx, 1; flag = Vx[0].
  - n=7: MINUS, Vy, Vx; flag = ~`alu_out[15]`.
  - n=E: LSHIFT, Vx, 1; flag = Vx[7].
- Result is `alu_out[7:0]`; wrap-around is modulo 256.
- WR_VX: `rf_we`=1, `rf_waddr`=x, `rf_wdata`=result. Flag ops (4, 5, 6, 7, E) go to WR_VF; all others go to DONE.
- WR_VF: `rf_we`=1, `rf_waddr`=F, `rf_wdata`={7'b0, flag}. Go to DONE.
- X=F with a flag op: VF is written twice, and the final value is the flag.
- Operands are captured in EXEC, so X=Y is legal and uses the same value for both operands.
- DONE: `done`=1, then go to IDLE.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `rf_we` = 0; `alu_sel`=ALU_f_NOP; all addresses, data and ALU operands = 0.
- Cycle sequence for `start` at cycle T:
  - T+1: READ.
  - T+2: EXEC.
  - T+3: WR_VX.
  - T+4: WR_VF for flag ops; otherwise DONE.
  - T+5: DONE for flag ops.
- Invalid n: DONE with `err` at T+1.
- Next `start` is accepted in the cycle after DONE (IDLE); back-to-back throughput is 5 or 6 cycles.
- `rf_we` is high for exactly one cycle per write; no write occurs outside WR_VX/WR_VF.
- `reset_n` low in any state: IDLE at the next edge, no `done` pulse, and `rf_we` is 0 from that edge.

## Test plan
- V1=0xFF, V2=0x01, start x=1 y=2 n=4:
  - WR_VX writes V1=0x00 at T+3.
  - WR_VF writes VF=0x01 at T+4.
  - `done` at T+5.
- V3=0x10, V4=0x20, n=5 (x=3, y=4) → V3=0xF0, VF=0x00. The same values with n=7 → V3=0x10, VF=0x01.
- V5=0x81, n=6 (x=5) → V5=0x40, VF=0x01. V5=0x81, n=E → V5=0x02, VF=0x01.
- n=2 with V6=0xF0, V7=0x3C → single write V6=0x30, no VF write, `done` at T+4. Repeat with n=9 → `done` and `err` at T+1, `rf_we` never asserted.
- x=F, y=0, VF=0x80, V0=0x80, n=4 → VF written 0x00 then 0x01; final VF=0x01.
- Assert `start` while busy → ignored. Drop `reset_n` during EXEC → IDLE at the next edge, no write, no `done`. A subsequent op completes normally.

Source files
------------

// File: rtl/chip8_alu_sequencer.sv
// Chip-8 8XYn arithmetic sequencer.
// Reads Vx/Vy, drives the shared ALU, writes Vx then VF over one port.
package chip8_pkg;

  typedef enum logic [3:0] {
    ALU_f_NOP    = 4'd0,
    ALU_f_OR     = 4'd1,
    ALU_f_AND    = 4'd2,
    ALU_f_XOR    = 4'd3,
    ALU_f_ADD    = 4'd4,
    ALU_f_MINUS  = 4'd5,
    ALU_f_RSHIFT = 4'd6,
    ALU_f_LSHIFT = 4'd7
  } ALU_f;

endpackage

module chip8_alu_sequencer
  import chip8_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op_x,
  input  logic [3:0]  op_y,
  input  logic [3:0]  op_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [7:0]  rf_rdata_a,
  input  logic [7:0]  rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output ALU_f        alu_sel,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic [15:0] alu_carry
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WR_VX,
    WR_VF,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] x_q;
  logic [3:0] n_q;
  logic       flag_q;
  logic       flag_c;
  logic [15:0] va;
  logic [15:0] vb;

  // Carry output and middle result bits play no part here.
  logic unused_bits;
  assign unused_bits = ^{alu_carry, alu_out[14:9]};

  function automatic logic n_valid(input logic [3:0] n);
    return (n <= 4'd7) || (n == 4'hE);
  endfunction

  function automatic logic n_flag(input logic [3:0] n);
    return (n >= 4'd4 && n <= 4'd7) || (n == 4'hE);
  endfunction

  function automatic ALU_f n_sel(input logic [3:0] n);
    ALU_f s;
    case (n)
      4'h0:    s = ALU_f_OR;
      4'h1:    s = ALU_f_OR;
      4'h2:    s = ALU_f_AND;
      4'h3:    s = ALU_f_XOR;
      4'h4:    s = ALU_f_ADD;
      4'h5:    s = ALU_f_MINUS;
      4'h6:    s = ALU_f_RSHIFT;
      4'h7:    s = ALU_f_MINUS;
      4'hE:    s = ALU_f_LSHIFT;
      default: s = ALU_f_NOP;
    endcase
    return s;
  endfunction

  assign va = {8'h00, rf_rdata_a};
  assign vb = {8'h00, rf_rdata_b};

  // Operand steering and flag extraction while the ALU is live in EXEC.
  always_comb begin
    alu_in1 = 16'h0000;
    alu_in2 = 16'h0000;
    flag_c  = 1'b0;
    if (state == EXEC) begin
      case (n_q)
        4'h0: begin
          alu_in1 = vb;
        end
        4'h1, 4'h2, 4'h3: begin
          alu_in1 = va;
          alu_in2 = vb;
        end
        4'h4: begin
          alu_in1 = va;
          alu_in2 = vb;
          flag_c  = alu_out[8];
        end
        4'h5: begin
          alu_in1 = va;
          alu_in2 = vb;
          flag_c  = ~alu_out[15];
        end
        4'h6: begin
          alu_in1 = va;
          alu_in2 = 16'h0001;
          flag_c  = rf_rdata_a[0];
        end
        4'h7: begin
          alu_in1 = vb;
          alu_in2 = va;
          flag_c  = ~alu_out[15];
        end
        4'hE: begin
          alu_in1 = va;
          alu_in2 = 16'h0001;
          flag_c  = rf_rdata_a[7];
        end
        default: begin
          alu_in1 = 16'h0000;
        end
      endcase
    end
  end

  // Sequencer FSM with registered handshake and write-port outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      x_q        <= 4'h0;
      n_q        <= 4'h0;
      flag_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rf_raddr_a <= 4'h0;
      rf_raddr_b <= 4'h0;
      rf_we      <= 1'b0;
      rf_waddr   <= 4'h0;
      rf_wdata   <= 8'h00;
      alu_sel    <= ALU_f_NOP;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      rf_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (n_valid(op_n)) begin
              x_q        <= op_x;
              n_q        <= op_n;
              rf_raddr_a <= op_x;
              rf_raddr_b <= op_y;
              state      <= READ;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          alu_sel <= n_sel(n_q);
          state   <= EXEC;
        end
        EXEC: begin
          flag_q   <= flag_c;
          alu_sel  <= ALU_f_NOP;
          rf_we    <= 1'b1;
          rf_waddr <= x_q;
          rf_wdata <= alu_out[7:0];
          state    <= WR_VX;
        end
        WR_VX: begin
          if (n_flag(n_q)) begin
            rf_we    <= 1'b1;
            rf_waddr <= 4'hF;
            rf_wdata <= {7'b0, flag_q};
            state    <= WR_VF;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        WR_VF: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed bench for chip8_alu_sequencer.
// Provides a behavioural ALU and a sync-read register file.
module tb_chip8_alu_sequencer;
  import chip8_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op_x, op_y, op_n;
  logic        busy, done, err;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [7:0]  rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  ALU_f        alu_sel;
  logic [15:0] alu_in1, alu_in2, alu_out, alu_carry;

  logic [7:0]  regs [16];
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  chip8_alu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .op_x(op_x), .op_y(op_y), .op_n(op_n),
    .busy(busy), .done(done), .err(err),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    alu_out   = 16'h0000;
    alu_carry = 16'h0000;
    case (alu_sel)
      ALU_f_OR:     alu_out = alu_in1 | alu_in2;
      ALU_f_AND:    alu_out = alu_in1 & alu_in2;
      ALU_f_XOR:    alu_out = alu_in1 ^ alu_in2;
      ALU_f_ADD:    alu_out = alu_in1 + alu_in2;
      ALU_f_MINUS:  alu_out = alu_in1 - alu_in2;
      ALU_f_RSHIFT: alu_out = alu_in1 >> alu_in2;
      ALU_f_LSHIFT: alu_out = alu_in1 << alu_in2;
      default:      alu_out = 16'h0000;
    endcase
  end

  // Register file: sync read, write on the clock edge
  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
    if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one valid op and follow it cycle by cycle.
  task automatic do_op(input logic [3:0] x, input logic [3:0] y,
                       input logic [3:0] n, input ALU_f sel,
                       input logic [7:0] res, input logic fl,
                       input bit fop, input bit poke);
    @(negedge clk);
    start = 1'b1; op_x = x; op_y = y; op_n = n;
    @(negedge clk);
    start = 1'b0;
    check("read_busy", busy, 1);
    check("read_ra", rf_raddr_a, x);
    check("read_rb", rf_raddr_b, y);
    check("read_we", rf_we, 0);
    if (poke) begin
      start = 1'b1; op_x = 4'h0; op_n = 4'h9;
    end
    @(negedge clk);
    check("exec_sel", alu_sel, sel);
    check("exec_we", rf_we, 0);
    @(negedge clk);
    start = 1'b0;
    check("wvx_we", rf_we, 1);
    check("wvx_addr", rf_waddr, x);
    check("wvx_data", rf_wdata, res);
    check("wvx_done", done, 0);
    @(negedge clk);
    if (fop) begin
      check("wvf_we", rf_we, 1);
      check("wvf_addr", rf_waddr, 4'hF);
      check("wvf_data", rf_wdata, {7'b0, fl});
      check("wvf_done", done, 0);
      @(negedge clk);
    end
    check("done", done, 1);
    check("done_err", err, 0);
    check("done_we", rf_we, 0);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  int w0;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    reset_n = 1'b0;
    start = 1'b0; op_x = 4'h0; op_y = 4'h0; op_n = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", rf_we, 0);
    check("rst_sel", alu_sel, ALU_f_NOP);
    check("rst_ra", rf_raddr_a, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_in1", alu_in1, 0);
    reset_n = 1'b1;

    // ADD with carry out
    regs[1] = 8'hFF; regs[2] = 8'h01;
    do_op(4'h1, 4'h2, 4'h4, ALU_f_ADD, 8'h00, 1'b1, 1, 0);
    check("add_v1", regs[1], 8'h00);
    check("add_vf", regs[15], 8'h01);

    // SUB with borrow, then SUBN without
    regs[3] = 8'h10; regs[4] = 8'h20;
    do_op(4'h3, 4'h4, 4'h5, ALU_f_MINUS, 8'hF0, 1'b0, 1, 0);
    check("sub_v3", regs[3], 8'hF0);
    check("sub_vf", regs[15], 8'h00);
    regs[3] = 8'h10;
    do_op(4'h3, 4'h4, 4'h7, ALU_f_MINUS, 8'h10, 1'b1, 1, 0);
    check("subn_v3", regs[3], 8'h10);
    check("subn_vf", regs[15], 8'h01);

    // Shifts
    regs[5] = 8'h81;
    do_op(4'h5, 4'h0, 4'h6, ALU_f_RSHIFT, 8'h40, 1'b1, 1, 0);
    check("shr_v5", regs[5], 8'h40);
    regs[15] = 8'h00;
    regs[5] = 8'h81;
    do_op(4'h5, 4'h0, 4'hE, ALU_f_LSHIFT, 8'h02, 1'b1, 1, 0);
    check("shl_v5", regs[5], 8'h02);
    check("shl_vf", regs[15], 8'h01);

    // AND: single write, VF untouched
    regs[6] = 8'hF0; regs[7] = 8'h3C; regs[15] = 8'hAA;
    do_op(4'h6, 4'h7, 4'h2, ALU_f_AND, 8'h30, 1'b0, 0, 0);
    check("and_v6", regs[6], 8'h30);
    check("and_vf", regs[15], 8'hAA);

    // Unsupported n
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; op_x = 4'h6; op_y = 4'h7; op_n = 4'h9;
    @(negedge clk);
    start = 1'b0;
    check("bad_done", done, 1);
    check("bad_err", err, 1);
    check("bad_busy", busy, 1);
    check("bad_we", rf_we, 0);
    @(negedge clk);
    check("bad_done2", done, 0);
    check("bad_err2", err, 0);
    check("bad_busy2", busy, 0);
    check("bad_wr", wr_cnt, w0);

    // X = F with flag op: VF written 00 then 01
    regs[15] = 8'h80; regs[0] = 8'h80;
    do_op(4'hF, 4'h0, 4'h4, ALU_f_ADD, 8'h00, 1'b1, 1, 0);
    check("xf_vf", regs[15], 8'h01);

    // Start while busy is ignored; LD and XOR
    regs[8] = 8'h12; regs[9] = 8'h40;
    do_op(4'h8, 4'h9, 4'h1, ALU_f_OR, 8'h52, 1'b0, 0, 1);
    check("or_v8", regs[8], 8'h52);
    check("or_v0", regs[0], 8'h80);
    do_op(4'h8, 4'h9, 4'h3, ALU_f_XOR, 8'h12, 1'b0, 0, 0);
    check("xor_v8", regs[8], 8'h12);
    regs[11] = 8'h5A;
    do_op(4'hA, 4'hB, 4'h0, ALU_f_OR, 8'h5A, 1'b0, 0, 0);
    check("ld_va", regs[10], 8'h5A);

    // X = Y
    regs[12] = 8'h33;
    do_op(4'hC, 4'hC, 4'h4, ALU_f_ADD, 8'h66, 1'b0, 1, 0);
    check("xy_vc", regs[12], 8'h66);
    check("xy_vf", regs[15], 8'h00);

    // Reset during EXEC
    regs[1] = 8'h7F; regs[2] = 8'h01;
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1; op_x = 4'h1; op_y = 4'h2; op_n = 4'h4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rx_sel", alu_sel, ALU_f_ADD);
    reset_n = 1'b0;
    @(negedge clk);
    check("rx_busy", busy, 0);
    check("rx_we", rf_we, 0);
    check("rx_done", done, 0);
    check("rx_sel0", alu_sel, ALU_f_NOP);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rx_done2", done, 0);
    check("rx_wr", wr_cnt, w0);
    check("rx_v1", regs[1], 8'h7F);

    // Normal op after reset
    do_op(4'h1, 4'h2, 4'h4, ALU_f_ADD, 8'h80, 1'b0, 1, 0);
    check("post_v1", regs[1], 8'h80);
    check("post_vf", regs[15], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
